// File: rtl/halflife_sequencer.sv
// Half-life decay sequencer: loads a count on start and halves it once per
// programmable period until it reaches zero, pulsing tick per halving and done at the end.
module halflife_sequencer #(
    parameter int W  = 8,
    parameter int PW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  init,
    input  logic [PW-1:0] period,
    output logic [W-1:0]  count,
    output logic [3:0]    halvings,
    output logic          busy,
    output logic          tick,
    output logic          done
);

    // state | meaning
    // IDLE  | waiting for an accepted start
    // RUN   | timer counting down, halving count at each terminal count
    // DONE  | single-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] timer, timer_d;
    logic [PW-1:0] per_q, per_d;
    logic [PW-1:0] per_eff;
    logic [W-1:0]  count_d;
    logic [W-1:0]  count_half;
    logic [3:0]    halv_d;
    logic          tick_d;

    assign per_eff    = (period == '0) ? PW'(1) : period;
    assign count_half = count >> 1;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            halvings <= '0;
            timer    <= '0;
            per_q    <= '0;
            tick     <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            halvings <= halv_d;
            timer    <= timer_d;
            per_q    <= per_d;
            tick     <= tick_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        halv_d  = halvings;
        timer_d = timer;
        per_d   = per_q;
        tick_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    count_d = init;
                    per_d   = per_eff;
                    timer_d = per_eff - PW'(1);
                    halv_d  = '0;
                    state_d = (init != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // abort outranks a coincident halving edge
                if (abort) begin
                    state_d = IDLE;
                end else if (timer != '0) begin
                    timer_d = timer - PW'(1);
                end else begin
                    count_d = count_half;
                    halv_d  = (halvings == 4'd15) ? halvings : halvings + 4'd1;
                    timer_d = per_q - PW'(1);
                    tick_d  = 1'b1;
                    if (count_half == '0) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
